dht11_sensor_emulator: RTL and testbench
========================================

Name: dht11_sensor_emulator

Overview:
Synthesizable single-wire responder that models a DHT11 humidity/temperature sensor. It sits on the dhtio bus opposite the dht11 host controller and enables on-board loopback tests and simulation without a physical sensor. It detects the host start pulse, then sends the 80 us sync low/high pair, 40 data bits MSB-first and a stop low. All timing is derived from a 1 us tick.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; tick period = CLK_FREQ_HZ/1_000_000 cycles (100).
START_MIN_US, 18000, minimum host low time accepted as a start.
RESP_WAIT_US, 30, delay from host release to the sensor pulling low.
SYNC_L_US, 80, sync low time.
SYNC_H_US, 80, sync high time.
BIT_L_US, 50, low preamble of every bit.
BIT0_H_US, 28, high time for bit 0.
BIT1_H_US, 70, high time for bit 1.
STOP_L_US, 50, final low before release.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  1 = respond to starts; 0 = stay released
hum_int  input  8  humidity integer byte
hum_dec  input  8  humidity decimal byte
tem_int  input  8  temperature integer byte
tem_dec  input  8  temperature decimal byte
csum_err  input  1  1 = send checksum XOR 8'h01
dhtio  inout  1  single-wire bus; driven 0/1 push-pull while responding, Z otherwise
busy  output  1  high from accepted start until release after stop
frame_done  output  1  1-cycle pulse when stop low ends
start_reject  output  1  1-cycle pulse when host low < START_MIN_US
frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (sync, at the clock edge): state=IDLE, dhtio=Z, busy=0, frame_done=0, start_reject=0, frame_cnt=0, all counters 0.
- Input path: dhtio passes through a 2-FF synchronizer. A falling/rising edge is detected on the synchronized value, giving 2-3 cycles of latency.
- Tick: a free-running divider pulses every CLK_FREQ_HZ/1e6 cycles. The divider restarts on every state entry, so each timed state lasts exactly N*100 cycles.
- States and transitions:
  - IDLE: Z. If enable and the bus falls -> HOST_LOW, and the us counter clears.
  - HOST_LOW: Z. Counts us while the bus is low; the counter saturates at 2^16-1.
    - On rising edge with count >= START_MIN_US: latch the 4 bytes and compute csum = (hum_int+hum_dec+tem_int+tem_dec) mod 256, XOR 8'h01 if csum_err. Form the 40-bit shift register {hum_int,hum_dec,tem_int,tem_dec,csum}. Go to RESP_WAIT with busy=1.
    - On rising edge with count < START_MIN_US: pulse start_reject and go to IDLE.
  - RESP_WAIT: Z for RESP_WAIT_US, then SYNC_L.
  - SYNC_L: drive 0 for SYNC_L_US, then SYNC_H.
  - SYNC_H: drive 1 for SYNC_H_US, then BIT_L with bit index 39.
  - BIT_L: drive 0 for BIT_L_US, then BIT_H.
  - BIT_H: drive 1 for BIT0_H_US or BIT1_H_US according to shreg[39]. Then shift left and decrement the index. After index 0 -> STOP_L, else BIT_L.
  - STOP_L: drive 0 for STOP_L_US. Then dhtio=Z, busy=0, frame_done pulse, frame_cnt+1 (wraps), -> IDLE.
- Input bytes are sampled only at start acceptance. Changes during a frame do not affect the frame in progress.
- enable=0 in any state other than IDLE: abort to IDLE on the next edge with dhtio=Z and busy=0. No frame_done, and frame_cnt is unchanged.
- enable rising while the bus is already low: no start. A falling edge is required.
- A bus falling edge during RESP_WAIT..STOP_L (host collision) is ignored; the frame continues.
- Host low held indefinitely: the counter saturates, and the start is accepted on release.
- Reset mid-frame: dhtio releases at that edge and all outputs return to reset values.
- Frame length: 80+80 + sum over bits (50 + 28/70) + 50 us, plus RESP_WAIT.

Test Plan:
- Nominal frame: enable=1, bytes {36,8,79,99}, bench host drives low 19 ms then releases.
  - dhtio goes low after 30 us ±3 cycles; 80 us low, then 80 us high.
  - 40 bits decode MSB-first to 24_08_4F_63_DE (csum 222).
  - frame_done pulses once and frame_cnt=1.
- Short start: host low 10 ms -> start_reject pulses 1 cycle; dhtio stays Z; busy=0; frame_cnt unchanged.
- Checksum injection: same bytes with csum_err=1 -> last byte decodes to 8'hDF (223); the other bytes are unchanged.
- Data change mid-frame: change hum_int to 50 during SYNC_H -> the frame still carries 36; the next frame carries 50.
- Abort: drop enable during bit 20 -> dhtio=Z on the next cycle, busy=0, no frame_done. A later valid start produces a complete frame.
- Reset mid-frame and wrap:
  - Assert rst during BIT_H -> dhtio=Z and frame_cnt=0 at that edge.
  - Run 256 frames (timing parameters reduced to 1 us) -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor emulator: answers a host start pulse on the single-wire bus with
// an 80/80 us sync pair, 40 data bits MSB-first and a final stop low.
module dht11_sensor_emulator #(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned RESP_WAIT_US = 30,
  parameter int unsigned SYNC_L_US    = 80,
  parameter int unsigned SYNC_H_US    = 80,
  parameter int unsigned BIT_L_US     = 50,
  parameter int unsigned BIT0_H_US    = 28,
  parameter int unsigned BIT1_H_US    = 70,
  parameter int unsigned STOP_L_US    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tem_int,
  input  logic [7:0] tem_dec,
  input  logic       csum_err,
  inout  wire        dhtio,
  output logic       busy,
  output logic       frame_done,
  output logic       start_reject,
  output logic [7:0] frame_cnt
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned US_W  = 16;

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, RESP_WAIT, SYNC_L, SYNC_H, BIT_L, BIT_H, STOP_L
  } state_t;

  state_t            state;
  logic [2:0]        sync;
  logic [DIV_W-1:0]  div;
  logic [US_W-1:0]   us;
  logic [39:0]       shreg;
  logic [5:0]        bit_idx;
  logic              oe;
  logic              dout;

  logic              tick_c;
  logic              fall_c;
  logic              rise_c;
  logic              last_c;
  logic [US_W-1:0]   dur_c;
  logic [7:0]        csum_c;

  assign dhtio  = oe ? dout : 1'bz;
  assign tick_c = (div == DIV_W'(DIV - 1));
  assign fall_c = sync[2] & ~sync[1];
  assign rise_c = ~sync[2] & sync[1];
  assign csum_c = (hum_int + hum_dec + tem_int + tem_dec) ^ {7'd0, csum_err};
  assign last_c = tick_c && (us == dur_c - 16'd1);

  // Length in microseconds of the current timed state
  always_comb begin
    dur_c = 16'd1;
    case (state)
      RESP_WAIT: dur_c = US_W'(RESP_WAIT_US);
      SYNC_L:    dur_c = US_W'(SYNC_L_US);
      SYNC_H:    dur_c = US_W'(SYNC_H_US);
      BIT_L:     dur_c = US_W'(BIT_L_US);
      BIT_H:     dur_c = shreg[39] ? US_W'(BIT1_H_US) : US_W'(BIT0_H_US);
      STOP_L:    dur_c = US_W'(STOP_L_US);
      default:   dur_c = 16'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= 3'b111;
      div          <= '0;
      us           <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      oe           <= 1'b0;
      dout         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      start_reject <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sync         <= {sync[1:0], dhtio};
      frame_done   <= 1'b0;
      start_reject <= 1'b0;
      div          <= tick_c ? '0 : div + DIV_W'(1);
      if (tick_c && us != '1) us <= us + 16'd1;

      if (state != IDLE && !enable) begin
        state <= IDLE;
        oe    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (enable && fall_c) begin
            state <= HOST_LOW;
            us    <= '0;
            div   <= '0;
          end
          HOST_LOW: if (rise_c) begin
            us  <= '0;
            div <= '0;
            if (us >= US_W'(START_MIN_US)) begin
              shreg <= {hum_int, hum_dec, tem_int, tem_dec, csum_c};
              busy  <= 1'b1;
              state <= RESP_WAIT;
            end else begin
              start_reject <= 1'b1;
              state        <= IDLE;
            end
          end
          RESP_WAIT: if (last_c) begin
            state <= SYNC_L; us <= '0; div <= '0; oe <= 1'b1; dout <= 1'b0;
          end
          SYNC_L: if (last_c) begin
            state <= SYNC_H; us <= '0; div <= '0; dout <= 1'b1;
          end
          SYNC_H: if (last_c) begin
            state <= BIT_L; us <= '0; div <= '0; dout <= 1'b0; bit_idx <= 6'd39;
          end
          BIT_L: if (last_c) begin
            state <= BIT_H; us <= '0; div <= '0; dout <= 1'b1;
          end
          BIT_H: if (last_c) begin
            us    <= '0;
            div   <= '0;
            dout  <= 1'b0;
            shreg <= {shreg[38:0], 1'b0};
            if (bit_idx == 6'd0) begin
              state <= STOP_L;
            end else begin
              bit_idx <= bit_idx - 6'd1;
              state   <= BIT_L;
            end
          end
          STOP_L: if (last_c) begin
            state      <= IDLE;
            oe         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Bench for dht11_sensor_emulator: host-side stimulus with a frame decoder/scoreboard
// on the bus, plus a fast second instance that exercises frame counter wrap.
module tb_dht11_sensor_emulator;

  localparam int unsigned CLK_HZ   = 2_000_000;
  localparam int unsigned DIV      = CLK_HZ / 1_000_000;
  localparam int unsigned START_US = 20;
  localparam int unsigned RESP_US  = 5;
  localparam int unsigned SL_US    = 4;
  localparam int unsigned SH_US    = 4;
  localparam int unsigned BL_US    = 2;
  localparam int unsigned B0_US    = 1;
  localparam int unsigned B1_US    = 3;
  localparam int unsigned STOP_US  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] hum_int = 8'd36, hum_dec = 8'd8, tem_int = 8'd79, tem_dec = 8'd99;
  logic       csum_err = 1'b0;
  logic       host_low = 1'b0;
  wire        bus;
  logic       busy, frame_done, start_reject;
  logic [7:0] frame_cnt;

  logic       host_w = 1'b0;
  wire        bus_w;
  logic       busy_w, fd_w, sr_w;
  logic [7:0] cnt_w;

  assign bus = host_low ? 1'b0 : 1'bz;
  pullup (bus);
  assign bus_w = host_w ? 1'b0 : 1'bz;
  pullup (bus_w);

  dht11_sensor_emulator #(
    .CLK_FREQ_HZ(CLK_HZ), .START_MIN_US(START_US), .RESP_WAIT_US(RESP_US),
    .SYNC_L_US(SL_US), .SYNC_H_US(SH_US), .BIT_L_US(BL_US),
    .BIT0_H_US(B0_US), .BIT1_H_US(B1_US), .STOP_L_US(STOP_US)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hum_int(hum_int), .hum_dec(hum_dec), .tem_int(tem_int), .tem_dec(tem_dec),
    .csum_err(csum_err), .dhtio(bus), .busy(busy), .frame_done(frame_done),
    .start_reject(start_reject), .frame_cnt(frame_cnt)
  );

  dht11_sensor_emulator #(
    .CLK_FREQ_HZ(1_000_000), .START_MIN_US(2), .RESP_WAIT_US(1),
    .SYNC_L_US(1), .SYNC_H_US(1), .BIT_L_US(1),
    .BIT0_H_US(1), .BIT1_H_US(1), .STOP_L_US(1)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(1'b1),
    .hum_int(hum_int), .hum_dec(hum_dec), .tem_int(tem_int), .tem_dec(tem_dec),
    .csum_err(1'b0), .dhtio(bus_w), .busy(busy_w), .frame_done(fd_w),
    .start_reject(sr_w), .frame_cnt(cnt_w)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: decodes pulse widths on the bus and scores each completed frame
  int          run = 0, lo_len = 0, sync_lo = 0, nbits = 0, rej_seen = 0, mcnt = 0;
  logic        prev = 1'b1;
  logic [39:0] word = '0;
  logic [39:0] e_mon;
  bit          in_frame = 1'b0, terr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mcnt = 0; in_frame = 0; nbits = 0; run = 0; prev = bus;
    end else begin
      if (frame_done) begin
        mcnt = (mcnt + 1) % 256;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("frame_data", word, e_mon);
          check("frame_bits", nbits, 40);
          check("bit_timing", terr, 0);
          check("sync_low_len", sync_lo, SL_US * DIV);
          check("stop_low_len", run, STOP_US * DIV);
        end
        check("frame_cnt", frame_cnt, mcnt);
        in_frame = 0;
      end
      if (start_reject) rej_seen++;
      if (bus === prev) begin
        run++;
      end else begin
        if (prev == 1'b1) begin
          if (busy && run == SH_US * DIV) begin
            in_frame = 1; nbits = 0; word = '0; terr = 0; sync_lo = lo_len;
          end else if (in_frame) begin
            if (run == B1_US * DIV) begin word = {word[38:0], 1'b1}; nbits++; end
            else if (run == B0_US * DIV) begin word = {word[38:0], 1'b0}; nbits++; end
            else terr = 1;
          end
        end else begin
          lo_len = run;
          if (in_frame && run != BL_US * DIV) terr = 1;
        end
        run = 1;
        prev = bus;
      end
      if (!busy && !frame_done) in_frame = 0;
    end
  end

  task automatic host_start(input int low_us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check({name, "_timeout"}, n >= 3000, 0);
    repeat (4) @(negedge clk);
  endtask

  // One valid start; checks response delay; optionally changes hum_int during sync high
  task automatic run_frame(input logic [39:0] exp, input bit mid_change);
    int n = 0;
    exp_q.push_back(exp);
    host_start(25);
    do begin @(negedge clk); n++; end while (bus !== 1'b0 && n < 200);
    check_rng("resp_wait_cycles", n, RESP_US * DIV + 2, RESP_US * DIV + 3);
    if (mid_change) begin
      n = 0;
      while (bus !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      hum_int = 8'd50;
    end
    wait_idle("frame");
  endtask

  initial begin
    int n;
    int r0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_start_reject", start_reject, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_bus_released", bus, 1);
    repeat (4) @(negedge clk);

    run_frame(40'h24_08_4F_63_DE, 1'b0);
    check("cnt_after_nominal", frame_cnt, 1);

    r0 = rej_seen;
    host_start(10);
    repeat (20) @(negedge clk);
    check("short_reject_pulses", rej_seen - r0, 1);
    check("short_busy", busy, 0);
    check("short_bus", bus, 1);
    check("short_cnt", frame_cnt, 1);

    csum_err = 1'b1;
    run_frame(40'h24_08_4F_63_DF, 1'b0);
    csum_err = 1'b0;

    run_frame(40'h24_08_4F_63_DE, 1'b1);
    run_frame(40'h32_08_4F_63_EC, 1'b0);
    hum_int = 8'd36;
    check("cnt_after_four", frame_cnt, 4);

    // Enable raised while the bus is already low must not start a frame
    enable = 1'b0;
    host_start(25);
    @(negedge clk);
    enable = 1'b0;
    host_low = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    host_low = 1'b0;
    repeat (20) @(negedge clk);
    check("enable_on_low_busy", busy, 0);

    // Abort during bit 20
    host_start(25);
    n = 0;
    while (!(in_frame && nbits == 20) && n < 2000) begin @(negedge clk); n++; end
    check("abort_reach_bit20", n >= 2000, 0);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_bus", bus, 1);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    check("abort_cnt", frame_cnt, 4);
    repeat (4) @(negedge clk);
    run_frame(40'h24_08_4F_63_DE, 1'b0);
    check("cnt_after_abort", frame_cnt, 5);

    // Reset in a bit-high phase
    host_start(25);
    n = 0;
    while (!(in_frame && nbits >= 5 && bus === 1'b1) && n < 2000) begin @(negedge clk); n++; end
    check("rst_reach_bit_high", n >= 2000, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus", bus, 1);
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(40'h24_08_4F_63_DE, 1'b0);
    check("cnt_after_midrst", frame_cnt, 1);

    // Counter wrap on the fast instance (frames of 1 us timings)
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      host_w = 1'b1;
      repeat (5) @(negedge clk);
      host_w = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!fd_w && n < 400);
      if (n >= 400) check("wrap_frame_timeout", i, 999);
      if (i == 0)   check("wrap_cnt_first", cnt_w, 1);
      if (i == 254) check("wrap_cnt_255", cnt_w, 255);
      if (i == 255) check("wrap_cnt_0", cnt_w, 0);
      repeat (3) @(negedge clk);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
